// File: rtl/hex_scan_display_pkg.sv
// hex_disp_pkg: shared constants and helpers for the multiplexed hex display.
// Holds the all-dark segment pattern, the 16-entry active-low decode table
// (index = nibble, bit order abcdefg on [1:7]) and the index-width helpers.
`timescale 1ns/1ps

package hex_disp_pkg;

  // All segments dark (common-anode, active-low segments).
  localparam logic [1:7] SEG_OFF = 7'b1111111;

  // Active-low abcdefg patterns; bit [1] is segment a, bit [7] is segment g.
  localparam logic [1:7] SEG_TABLE [16] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  // Digit index width; a single-digit display still carries a 1-bit index.
  function automatic int idx_w(input int digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

  // Prescaler width; a divide-by-1 prescaler still needs one register bit.
  function automatic int cnt_w(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/hex_scan_display_if.sv
// hex_scan_display_if: bundles the datapath-facing inputs and pin-facing outputs.
// master: the producer of value/load/dp/blank_mask/lz_en that observes the pins.
// slave : the display driver that consumes the inputs and drives seg/dp_n/an.
// Ports (signals): value[4*DIGITS], load, dp[DIGITS], blank_mask[DIGITS], lz_en,
//   seg[1:7] (active low), dp_n (active low), an[DIGITS] (active low), digit_idx.
`timescale 1ns/1ps

interface hex_scan_display_if #(
  parameter int DIGITS = 4,
  parameter int IDX_W  = hex_disp_pkg::idx_w(DIGITS)
) ();

  logic [4*DIGITS-1:0] value;
  logic                load;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blank_mask;
  logic                lz_en;

  logic [1:7]          seg;
  logic                dp_n;
  logic [DIGITS-1:0]   an;
  logic [IDX_W-1:0]    digit_idx;

  modport master (
    output value, load, dp, blank_mask, lz_en,
    input  seg, dp_n, an, digit_idx
  );

  modport slave (
    input  value, load, dp, blank_mask, lz_en,
    output seg, dp_n, an, digit_idx
  );

endinterface

// File: rtl/hex_digit_decode.sv
// hex_digit_decode: 4-bit hex nibble to active-low abcdefg segment pattern.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the nibble continuously.
// Ports: nibble[3:0] in, seg[1:7] out (bit 1 = segment a, active low).
`timescale 1ns/1ps

module hex_digit_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [1:7] seg
);

  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_scan_display.sv
// hex_scan_display: time-multiplexed common-anode hex display driver with
//   shadowed input, guard-blanked refresh scan, per-digit blank/dp, leading-zero suppression.
// Latency: outputs are registered, one cycle behind prescaler/digit_idx/shadow state.
// Backpressure: none; load is a one-cycle capture strobe and is always accepted.
// Ports: clk, reset (sync, active high), bus (hex_scan_display_if.slave):
//   value/load/dp/blank_mask/lz_en in; seg/dp_n/an (active low) and digit_idx out.
`timescale 1ns/1ps

module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2,
  parameter int CNT_W       = cnt_w(REFRESH_DIV),
  parameter int IDX_W       = idx_w(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  hex_scan_display_if.slave bus
);

  // Shadow copies of the display content, so a multi-cycle update of the
  // datapath result never shows a torn mix of old and new digits.
  logic [4*DIGITS-1:0] shadow_value;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   shadow_blank;

  // Scan state.
  logic [CNT_W-1:0]    prescaler;
  logic [IDX_W-1:0]    digit_idx;
  logic                slot_tick;
  logic                in_guard;

  // Current-digit datapath.
  logic [3:0]          nibble;
  logic [1:7]          dec_seg;
  logic                upper_nz;
  logic                dark;
  logic [DIGITS-1:0]   an_active;

  // Output registers.
  logic [1:7]          seg_q;
  logic                dp_n_q;
  logic [DIGITS-1:0]   an_q;

  assign slot_tick = (prescaler == CNT_W'(REFRESH_DIV - 1));

  // The first GUARD cycles of each slot keep every anode off so the previous
  // digit's pattern cannot ghost onto the next anode while segments settle.
  assign in_guard  = (int'(prescaler) < GUARD);

  assign nibble    = shadow_value[4*int'(digit_idx) +: 4];

  hex_digit_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // A digit is a leading zero when it and every more-significant nibble are
  // zero. Digit 0 is exempt, so an all-zero value still shows a single "0".
  always_comb begin
    upper_nz = 1'b0;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(digit_idx)) && (shadow_value[4*j +: 4] != 4'h0)) begin
        upper_nz = 1'b1;
      end
    end
  end

  // lz_en is taken live rather than shadowed: it is a display mode, not data.
  assign dark = shadow_blank[digit_idx] |
                (bus.lz_en && (digit_idx != '0) && !upper_nz);

  // One-hot active-low anode for the slot owner. A dark digit keeps its anode
  // enabled; only the segments go off, which keeps the scan duty uniform.
  always_comb begin
    an_active            = '1;
    an_active[digit_idx] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      prescaler    <= '0;
      digit_idx    <= '0;
      seg_q        <= SEG_OFF;
      dp_n_q       <= 1'b1;
      an_q         <= '1;
    end else begin
      if (bus.load) begin
        shadow_value <= bus.value;
        shadow_dp    <= bus.dp;
        shadow_blank <= bus.blank_mask;
      end

      if (slot_tick) begin
        prescaler <= '0;
        if (digit_idx == IDX_W'(DIGITS - 1)) begin
          digit_idx <= '0;
        end else begin
          digit_idx <= digit_idx + IDX_W'(1);
        end
      end else begin
        prescaler <= prescaler + CNT_W'(1);
      end

      if (in_guard) begin
        seg_q  <= SEG_OFF;
        dp_n_q <= 1'b1;
        an_q   <= '1;
      end else begin
        seg_q  <= dark ? SEG_OFF : dec_seg;
        dp_n_q <= dark | ~shadow_dp[digit_idx];
        an_q   <= an_active;
      end
    end
  end

  assign bus.seg       = seg_q;
  assign bus.dp_n      = dp_n_q;
  assign bus.an        = an_q;
  assign bus.digit_idx = digit_idx;

endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: table-driven scoreboard bench for hex_scan_display
// (DIGITS=4, REFRESH_DIV=4, GUARD=1). Expected per-digit patterns are hand
// written in the vector table; a small timing model places them in the scan.
`timescale 1ns/1ps

module tb_hex_scan_display;

  localparam int DIGITS      = 4;
  localparam int REFRESH_DIV = 4;
  localparam int GUARD       = 1;

  typedef struct {
    string       name;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz;
    logic [6:0]  seg [4];   // expected pattern for digit i
    logic [3:0]  dpn;       // expected dp_n for digit i
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic [1:0] idx;
  } out_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hex_scan_display_if #(.DIGITS(DIGITS)) bus ();

  hex_scan_display #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .GUARD       (GUARD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  vec_t tbl [8];
  int   cur;
  int   pre_m;
  int   idx_m;
  int   n_vec;
  int   n_bad;
  out_t sb [$];

  task automatic set_vec(input int k, input string name, input logic [15:0] value,
                         input logic [3:0] dp, input logic [3:0] blank, input logic lz,
                         input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3,
                         input logic [3:0] dpn);
    tbl[k].name   = name;
    tbl[k].value  = value;
    tbl[k].dp     = dp;
    tbl[k].blank  = blank;
    tbl[k].lz     = lz;
    tbl[k].seg[0] = s0;
    tbl[k].seg[1] = s1;
    tbl[k].seg[2] = s2;
    tbl[k].seg[3] = s3;
    tbl[k].dpn    = dpn;
  endtask

  // One clock edge. When chk is set, the expected outputs for this edge are
  // pushed before the edge and popped/compared #1 after it.
  task automatic step(input bit chk, input string tag);
    out_t e;
    out_t w;
    out_t got;
    int   npre;
    int   nidx;
    if (reset) begin
      npre = 0;
      nidx = 0;
    end else begin
      npre = (pre_m == REFRESH_DIV - 1) ? 0 : pre_m + 1;
      nidx = (pre_m == REFRESH_DIV - 1) ? (idx_m + 1) % DIGITS : idx_m;
    end
    if (reset || pre_m < GUARD) begin
      e.an  = 4'b1111;
      e.seg = 7'b1111111;
      e.dpn = 1'b1;
    end else begin
      e.an  = ~(4'b0001 << idx_m);
      e.seg = tbl[cur].seg[idx_m];
      e.dpn = tbl[cur].dpn[idx_m];
    end
    e.idx = 2'(nidx);
    if (chk) sb.push_back(e);
    @(posedge clk);
    #1;
    pre_m = npre;
    idx_m = nidx;
    if (chk) begin
      got = {bus.an, bus.seg, bus.dp_n, bus.digit_idx};
      w   = sb.pop_front();
      n_vec++;
      if (got !== w) begin
        n_bad++;
        $display("FAIL %s: got an=%b seg=%b dp_n=%b idx=%0d, want an=%b seg=%b dp_n=%b idx=%0d",
                 tag, got.an, got.seg, got.dpn, got.idx, w.an, w.seg, w.dpn, w.idx);
      end
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, tag);
  endtask

  // Wait (checked) until the model is at the given prescaler/digit, then
  // pulse load with vector k on that edge and check a full scan after it.
  // The load edge itself is not checked because lz_en changes live with it.
  task automatic load_vec(input int k, input int at_pre, input int at_idx, input string tag);
    for (int g = 0; g < REFRESH_DIV * DIGITS && !(pre_m == at_pre && idx_m == at_idx); g++)
      step(1'b1, tag);
    bus.value      = tbl[k].value;
    bus.dp         = tbl[k].dp;
    bus.blank_mask = tbl[k].blank;
    bus.lz_en      = tbl[k].lz;
    bus.load       = 1'b1;
    step(1'b0, tag);
    bus.load       = 1'b0;
    cur            = k;
    run(REFRESH_DIV * DIGITS, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    pre_m = 0;
    idx_m = 0;
    cur   = 0;

    set_vec(0, "cleared",  16'h0000, 4'b0000, 4'b0000, 1'b0,
            7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1111);
    set_vec(1, "zero_lz",  16'h0000, 4'b0000, 4'b0000, 1'b1,
            7'b0000001, 7'b1111111, 7'b1111111, 7'b1111111, 4'b1111);
    set_vec(2, "h0050_lz", 16'h0050, 4'b0000, 4'b0000, 1'b1,
            7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111, 4'b1111);
    set_vec(3, "h12af",    16'h12AF, 4'b0000, 4'b0000, 1'b0,
            7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111, 4'b1111);
    set_vec(4, "h8888_bl", 16'h8888, 4'b0010, 4'b0100, 1'b0,
            7'b0000000, 7'b0000000, 7'b1111111, 7'b0000000, 4'b1101);
    set_vec(5, "h3047_lz", 16'h3047, 4'b1111, 4'b0000, 1'b1,
            7'b0001111, 7'b1001100, 7'b0000001, 7'b0000110, 4'b0000);
    set_vec(6, "hbcde_bl", 16'hBCDE, 4'b0001, 4'b0001, 1'b0,
            7'b1111111, 7'b1000010, 7'b0110001, 7'b1100000, 4'b1111);
    set_vec(7, "h9630_lz", 16'h9630, 4'b0000, 4'b0000, 1'b1,
            7'b0000001, 7'b0000110, 7'b0100000, 7'b0000100, 4'b1111);

    reset          = 1'b1;
    bus.value      = '0;
    bus.load       = 1'b0;
    bus.dp         = '0;
    bus.blank_mask = '0;
    bus.lz_en      = 1'b0;

    // Reset held three cycles: everything dark, index 0.
    run(3, "reset");
    reset = 1'b0;
    cur   = 0;
    // Guard cycle, then digit 0 of the cleared shadow.
    run(8, "post_reset");

    // Main table: each vector loaded on the digit3 -> digit0 slot tick.
    for (int k = 1; k < 8; k++) load_vec(k, REFRESH_DIV - 1, DIGITS - 1, tbl[k].name);

    // Inputs change without load: display must keep the shadow.
    bus.value      = 16'hFFFF;
    bus.dp         = 4'b1111;
    bus.blank_mask = 4'b1010;
    run(REFRESH_DIV * DIGITS, "no_load");

    // Load on the slot tick into digit 2: that slot already shows new data.
    load_vec(3, REFRESH_DIV - 1, 1, "load_on_tick");

    // Load mid-slot of digit 1: new pattern from the following cycle.
    load_vec(6, 2, 1, "load_mid_slot");

    // Reset while digit 2 is active: next cycle dark, scan restarts at
    // digit 0 after a guard cycle, with the shadow cleared.
    for (int g = 0; g < REFRESH_DIV * DIGITS && !(pre_m == 2 && idx_m == 2); g++)
      step(1'b1, "pre_rst_mid");
    reset = 1'b1;
    step(1'b1, "rst_mid");
    reset = 1'b0;
    cur   = bus.lz_en ? 1 : 0;
    run(REFRESH_DIV * DIGITS, "after_rst_mid");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
